// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state codes
// and the request legality check used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE  = 3'd0;
  localparam lsu_state_t ST_RD    = 3'd1;
  localparam lsu_state_t ST_CAP   = 3'd2;
  localparam lsu_state_t ST_MERGE = 3'd3;
  localparam lsu_state_t ST_WR    = 3'd4;
  localparam lsu_state_t ST_RESP  = 3'd5;

  // Returns 1 when the request must be answered with a fault and never reach memory.
  function automatic logic lsu_fault(input logic        is_store,
                                     input logic [2:0]  funct3,
                                     input logic [31:0] addr,
                                     input logic [31:0] mem_words);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr[0];
      F3_W:        bad = (addr[1:0] != 2'b00);
      default:     bad = 1'b1;
    endcase
    if (is_store && funct3[2]) bad = 1'b1;
    if ({2'b00, addr[31:2]} >= mem_words) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges sub-word store data into the old word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
    logic [31:0] sh;
    logic [31:0] res;
    // Halves are always 2-byte aligned here, so one byte-granular shift serves both.
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   res = {24'h0, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   res = {16'h0, sh[15:0]};
      F3_W:    res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] wd,
                                        input logic [1:0]  off,
                                        input logic [2:0]  f3);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] lane;
    sh = {off, 3'b000};
    case (f3)
      F3_B: begin
        mask = 32'h0000_00FF << sh;
        lane = {24'h0, wd[7:0]} << sh;
      end
      F3_H: begin
        mask = 32'h0000_FFFF << sh;
        lane = {16'h0, wd[15:0]} << sh;
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        lane = wd;
      end
    endcase
    return (old_word & ~mask) | lane;
  endfunction

  assign load_data  = extract(rd_word, offset, funct3);
  assign merge_data = merge(rd_word, wdata, offset, funct3);

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed requests into word accesses on a
// synchronous-read data memory, with read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_should_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_should_write_q, mem_should_write_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [31:0] load_data;
  logic [31:0] merge_data;

  lsu_lane_align u_align (
    .rd_word    (mem_read_data),
    .wdata      (wdata_q),
    .offset     (offset_q),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    state_d            = state_q;
    is_store_d         = is_store_q;
    funct3_d           = funct3_q;
    offset_d           = offset_q;
    wdata_d            = wdata_q;
    mem_addr_d         = mem_addr_q;
    mem_write_data_d   = mem_write_data_q;
    resp_rdata_d       = resp_rdata_q;
    mem_should_write_d = 1'b0;
    resp_valid_d       = 1'b0;
    resp_fault_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_store_d   = req_is_store;
          funct3_d     = req_funct3;
          offset_d     = req_addr[1:0];
          wdata_d      = req_wdata;
          resp_rdata_d = 32'h0;
          if (lsu_fault(req_is_store, req_funct3, req_addr, 32'(MEM_WORDS))) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            mem_addr_d = {2'b00, req_addr[31:2]};
            if (req_is_store && (req_funct3 == F3_W)) begin
              state_d            = ST_WR;
              mem_should_write_d = 1'b1;
              mem_write_data_d   = req_wdata;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD:    state_d = is_store_q ? ST_MERGE : ST_CAP;
      ST_CAP: begin
        state_d      = ST_RESP;
        resp_rdata_d = load_data;
        resp_valid_d = 1'b1;
      end
      ST_MERGE: begin
        state_d            = ST_WR;
        mem_should_write_d = 1'b1;
        mem_write_data_d   = merge_data;
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      is_store_q         <= 1'b0;
      funct3_q           <= 3'b000;
      offset_q           <= 2'b00;
      wdata_q            <= 32'h0;
      mem_addr_q         <= 32'h0;
      mem_should_write_q <= 1'b0;
      mem_write_data_q   <= 32'h0;
      resp_valid_q       <= 1'b0;
      resp_fault_q       <= 1'b0;
      resp_rdata_q       <= 32'h0;
    end else begin
      state_q            <= state_d;
      is_store_q         <= is_store_d;
      funct3_q           <= funct3_d;
      offset_q           <= offset_d;
      wdata_q            <= wdata_d;
      mem_addr_q         <= mem_addr_d;
      mem_should_write_q <= mem_should_write_d;
      mem_write_data_q   <= mem_write_data_d;
      resp_valid_q       <= resp_valid_d;
      resp_fault_q       <= resp_fault_d;
      resp_rdata_q       <= resp_rdata_d;
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_fault       = resp_fault_q;
  assign resp_rdata       = resp_rdata_q;
  assign mem_addr         = mem_addr_q;
  assign mem_should_write = mem_should_write_q;
  assign mem_write_data   = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner
// cases, held-request streaming and random traffic against a byte-level model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_should_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_addr         (mem_addr),
    .mem_should_write (mem_should_write),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: synchronous read, write on the falling edge; preload port for the bench.
  logic [31:0] mem [0:1023];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) mem_read_data <= mem[mem_addr[9:0]];

  always @(negedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_should_write) mem[mem_addr[9:0]] <= mem_write_data;
  end

  // Reference model state: byte-addressed little-endian memory.
  logic [7:0] ref_bytes [0:4095];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pre_idx = idx[9:0];
    pre_val = val;
    pre_en  = 1'b1;
    for (int b = 0; b < 4; b++) ref_bytes[idx * 4 + b] = val[8 * b +: 8];
    @(negedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Behavioural model computed from access size, alignment and byte lanes.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                       output int lat, output int nw);
    int size;
    int base;
    longint unsigned v;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    rd  = 32'h0;
    nw  = 0;
    flt = (size == 0) || (st && f3[2]);
    if (!flt) flt = ((a % size) != 0) || ((a / 4) >= 1024);
    base = int'(a[11:0]);
    if (flt) begin
      lat = 1;
    end else if (st) begin
      for (int i = 0; i < size; i++) ref_bytes[base + i] = wd[8 * i +: 8];
      nw  = 1;
      lat = (size == 4) ? 2 : 4;
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(ref_bytes[base + i]) << (8 * i));
      if (!f3[2] && (((v >> (8 * size - 1)) & 1) == 1)) v = v | (64'hFFFF_FFFF << (8 * size));
      rd  = v[31:0];
      lat = 3;
    end
  endtask

  // Issues one request and observes it; latency 1 is the cycle right after the accepting edge.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output int nw, output logic [31:0] waddr);
    int w;
    rd = 32'h0; flt = 1'b0; lat = -1; nw = 0; waddr = 32'hFFFF_FFFF;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, w);
    end
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_should_write) begin
        nw++;
        waddr = mem_addr;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        flt = resp_fault;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_check(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_flt,
                           input int exp_lat, input int exp_nw);
    logic [31:0] rd, waddr;
    logic        flt;
    int          lat, nw;
    do_req(st, f3, a, wd, rd, flt, lat, nw, waddr);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_fault"}, 32'(flt), 32'(exp_flt));
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_write_pulses"}, nw, exp_nw);
    if (exp_nw == 1) check({tag, "_write_index"}, waddr, a >> 2);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_writes;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

  task automatic gen_req(input int k);
    int sz;
    req_is_store = k[0];
    req_funct3   = req_is_store ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
    sz = (req_funct3[1:0] == 2'b00) ? 1 : (req_funct3[1:0] == 2'b01) ? 2 : 4;
    req_addr  = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3 / sz) * sz);
    req_wdata = $urandom;
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } pend_t;

  initial begin
    logic [31:0] m_rd;
    logic        m_flt;
    int          m_lat, m_nw;
    pend_t       pq[$];
    pend_t       p;
    logic        rdy;
    int          k, nresp, cyc, spurious, hits;
    localparam int NHELD = 24;

    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; pre_en = 1'b0; pre_idx = 10'h0; pre_val = 32'h0;

    for (int i = 0; i < 1024; i++) preload(i, $urandom);
    preload(5, 32'h80FF_7F01);
    preload(1023, 32'h0BAD_F00D);
    @(posedge clk); #1;
    reset = 1'b0;

    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_resp_fault", 32'(resp_fault), 32'h0);
    check("reset_mem_should_write", 32'(mem_should_write), 32'h0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_write_data", mem_write_data, 32'h0);

    vecs[0]  = '{1'b0, 3'b000, 32'h16,   32'h0,         32'hFFFF_FFFF, 1'b0, 3, 0};
    vecs[1]  = '{1'b0, 3'b100, 32'h16,   32'h0,         32'h0000_00FF, 1'b0, 3, 0};
    vecs[2]  = '{1'b0, 3'b001, 32'h16,   32'h0,         32'hFFFF_80FF, 1'b0, 3, 0};
    vecs[3]  = '{1'b0, 3'b101, 32'h14,   32'h0,         32'h0000_7F01, 1'b0, 3, 0};
    vecs[4]  = '{1'b0, 3'b010, 32'h14,   32'h0,         32'h80FF_7F01, 1'b0, 3, 0};
    vecs[5]  = '{1'b1, 3'b010, 32'h20,   32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1};
    vecs[6]  = '{1'b0, 3'b010, 32'h20,   32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0};
    vecs[7]  = '{1'b1, 3'b000, 32'h21,   32'h1234_5655, 32'h0,         1'b0, 4, 1};
    vecs[8]  = '{1'b0, 3'b010, 32'h20,   32'h0,         32'hDEAD_55EF, 1'b0, 3, 0};
    vecs[9]  = '{1'b1, 3'b001, 32'h22,   32'h0000_CAFE, 32'h0,         1'b0, 4, 1};
    vecs[10] = '{1'b0, 3'b010, 32'h20,   32'h0,         32'hCAFE_55EF, 1'b0, 3, 0};
    vecs[11] = '{1'b0, 3'b010, 32'h22,   32'h0,         32'h0,         1'b1, 1, 0};
    vecs[12] = '{1'b0, 3'b001, 32'h23,   32'h0,         32'h0,         1'b1, 1, 0};
    vecs[13] = '{1'b1, 3'b010, 32'h1000, 32'h1,         32'h0,         1'b1, 1, 0};
    vecs[14] = '{1'b0, 3'b011, 32'h20,   32'h0,         32'h0,         1'b1, 1, 0};
    vecs[15] = '{1'b1, 3'b101, 32'h20,   32'h5,         32'h0,         1'b1, 1, 0};
    vecs[16] = '{1'b0, 3'b010, 32'hFFC,  32'h0,         32'h0BAD_F00D, 1'b0, 3, 0};
    vecs[17] = '{1'b1, 3'b010, 32'hFFC,  32'h1122_3344, 32'h0,         1'b0, 2, 1};
    vecs[18] = '{1'b0, 3'b000, 32'hFFF,  32'h0,         32'h0000_0011, 1'b0, 3, 0};
    vecs[19] = '{1'b0, 3'b001, 32'hFFE,  32'h0,         32'h0000_1122, 1'b0, 3, 0};
    vecs[20] = '{1'b0, 3'b000, 32'h15,   32'h0,         32'h0000_007F, 1'b0, 3, 0};
    vecs[21] = '{1'b0, 3'b001, 32'h14,   32'h0,         32'h0000_7F01, 1'b0, 3, 0};
    vecs[22] = '{1'b0, 3'b101, 32'h16,   32'h0,         32'h0000_80FF, 1'b0, 3, 0};

    for (int i = 0; i < NVEC; i++) begin
      model(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rd, m_flt, m_lat, m_nw);
      run_check($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_fault, vecs[i].exp_lat, vecs[i].exp_writes);
    end

    // Reset during MERGE of an SB: request abandoned, word untouched.
    preload(10, 32'h0102_0304);
    @(posedge clk); #1;
    req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h29; req_wdata = 32'h0000_00AA;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_merge_ready", 32'(req_ready), 32'h1);
    check("rst_merge_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_merge_write", 32'(mem_should_write), 32'h0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid || mem_should_write) hits++;
      @(posedge clk); #1;
    end
    check("rst_merge_quiet", hits, 0);
    run_check("rst_merge_word", 1'b0, 3'b010, 32'h28, 32'h0, 32'h0102_0304, 1'b0, 3, 0);

    // Reset during WR of an SW: the falling-edge write still lands.
    preload(11, 32'h0);
    @(posedge clk); #1;
    req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2C; req_wdata = 32'h5566_7788;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_wr_write_high", 32'(mem_should_write), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_wr_resp_valid", 32'(resp_valid), 32'h0);
    model(1'b1, 3'b010, 32'h2C, 32'h5566_7788, m_rd, m_flt, m_lat, m_nw);
    run_check("rst_wr_word", 1'b0, 3'b010, 32'h2C, 32'h0, 32'h5566_7788, 1'b0, 3, 0);

    // req_valid held high with alternating loads and stores.
    @(posedge clk); #1;
    k = 0; nresp = 0; cyc = 0; spurious = 0;
    gen_req(0);
    req_valid = 1'b1;
    while (nresp < NHELD && cyc < 2000) begin
      rdy = req_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy && req_valid) begin
        model(req_is_store, req_funct3, req_addr, req_wdata, m_rd, m_flt, m_lat, m_nw);
        pq.push_back('{m_rd, m_flt, m_lat, cyc});
        k++;
        if (k < NHELD) gen_req(k);
        else req_valid = 1'b0;
      end
      if (resp_valid) begin
        check("held_ready_in_resp", 32'(req_ready), 32'h0);
        if (pq.size() == 0) begin
          spurious++;
        end else begin
          p = pq.pop_front();
          check($sformatf("held%0d_rdata", nresp), resp_rdata, p.rdata);
          check($sformatf("held%0d_fault", nresp), 32'(resp_fault), 32'(p.fault));
          check($sformatf("held%0d_latency", nresp), cyc - p.acc + 1, p.lat);
        end
        nresp++;
      end
    end
    req_valid = 1'b0;
    check("held_responses", nresp, NHELD);
    check("held_spurious", spurious, 0);
    check("held_pending", pq.size(), 0);

    // Random traffic, including illegal funct3, misalignment and out-of-range addresses.
    for (int i = 0; i < 300; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      wd = $urandom;
      model(st, f3, a, wd, m_rd, m_flt, m_lat, m_nw);
      run_check($sformatf("rnd%0d", i), st, f3, a, wd, m_rd, m_flt, m_lat, m_nw);
    end

    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++)
      check($sformatf("mem_word_%0d", i), mem[i],
            {ref_bytes[4 * i + 3], ref_bytes[4 * i + 2], ref_bytes[4 * i + 1], ref_bytes[4 * i]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute/memory stage and the word-addressed data memory.
- Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
- Misaligned, out-of-range and illegal requests are faulted without touching memory.

Parameters:
- MEM_WORDS, 1024, data memory depth in 32-bit words; word index must be < MEM_WORDS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready at a rising edge.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid: misaligned, out-of-range or illegal funct3.
- mem_addr  out  32  word index = {2'b00, addr[31:2]}, registered.
- mem_should_write  out  1  registered write enable to memory.
- mem_write_data  out  32  registered write word.
- mem_read_data  in  32  memory read port; valid one cycle after mem_addr is presented.

Behaviour:
- Reset: state=IDLE. resp_valid, resp_fault, mem_should_write = 0; resp_rdata, mem_addr, mem_write_data = 0.
- Reset mid-operation abandons the request at that edge, with no response.
  - A write whose WR cycle began before reset still completes, because memory writes on the falling edge inside that cycle.
- States: IDLE, RD, CAP, MERGE, WR, RESP.
- On accept, latch is_store, funct3, addr[1:0], wdata and word index.
- Fault check at accept; on fault go directly to RESP with resp_fault=1. Fault conditions:
  - funct3 not in {000,001,010,100,101};
  - store with funct3[2]=1;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
- Load path: IDLE→RD (mem_addr driven)→CAP (mem_read_data valid)→RESP.
  - CAP registers resp_rdata:
    - B/BU select byte addr[1:0]; H/HU select half addr[1].
    - B/H sign-extend; BU/HU zero-extend.
  - resp_valid is high in the RESP cycle, i.e. 3 cycles after accept.
- Store word: IDLE→WR.
  - mem_should_write=1 and mem_write_data=wdata during WR.
  - WR→RESP; resp_valid 2 cycles after accept.
- Store byte/half: IDLE→RD→MERGE→WR→RESP.
  - MERGE replaces the selected lane of mem_read_data with wdata[7:0] or wdata[15:0] and keeps the other lanes.
  - resp_valid 4 cycles after accept.
- mem_should_write is high only in WR, never for faulted or load requests.
- RESP→IDLE unconditionally; the response has no backpressure and req_ready=0 during RESP.
- A request held in RESP cannot be accepted the same cycle. Back-to-back issue is one request per (latency+1) cycles.
- req_valid while busy is ignored; the core must hold the request until req_ready.

Decomposition:
- lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum;
  - a function computing the fault condition.
- Sub-module lsu_lane_align (combinational) with two functions:
  - extract: word, addr[1:0], funct3 → extended load data;
  - merge: old word, wdata, addr[1:0], funct3 → merged store word.
- The top holds the FSM and the registers.

Test Plan:
- Memory word 5 = 0x80FF_7F01 (word index 5); LB addr 0x16 → resp_rdata 0xFFFF_FFFF. LBU addr 0x16 → 0x0000_00FF. LH addr 0x16 → 0xFFFF_80FF. resp_valid 3 cycles after accept.
- SW addr 0x20, wdata 0xDEAD_BEEF → one mem_should_write pulse with mem_addr=8; resp 2 cycles after accept; a following LW 0x20 returns 0xDEAD_BEEF.
- Word 8 = 0xDEAD_BEEF; SB addr 0x21 wdata 0x1234_5655 → word 8 = 0xDEAD_55EF. SH addr 0x22 wdata 0x0000_CAFE → 0xCAFE_55EF. resp 4 cycles after accept.
- LW addr 0x22, LH addr 0x23, SW addr 0x1000 (index 1024), funct3=011 → each returns resp_fault=1 and resp_rdata=0 one cycle after accept; mem_should_write never asserts.
- Assert reset in MERGE of an SB → no WR, no resp_valid, req_ready=1 next cycle, target word unchanged.
- req_valid held continuously with alternating loads and stores → accepts only in IDLE, exactly one resp_valid per accepted request, in order.
